// File: rtl/mips_mem_pkg.sv
// Shared memory-side widths and the store-buffer entry layout.
package mips_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 24;
    localparam int unsigned DEF_DATA_W = 24;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_forward_mux.sv
// Picks the youngest valid buffered entry whose address matches the lookup address.
module sb_forward_mux #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 24
) (
    input  logic [ADDR_W-1:0]         entry_addr_i [DEPTH],
    input  logic [DATA_W-1:0]         entry_data_i [DEPTH],
    input  logic [DEPTH-1:0]          valid_i,
    input  logic [$clog2(DEPTH)-1:0]  tail_i,
    input  logic [ADDR_W-1:0]         lookup_addr_i,
    output logic                      hit_o,
    output logic [DATA_W-1:0]         data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk from oldest to youngest so the youngest match is the last assignment.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = tail_i - PTR_W'(k + 1);
            if (valid_i[idx] && (entry_addr_i[idx] == lookup_addr_i)) begin
                hit_o  = 1'b1;
                data_o = entry_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending stores drained to memory when loads leave the port free,
// with youngest-entry forwarding to loads.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_w,
    output logic              mem_r,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [DEPTH-1:0]  valid_mask;
    logic              load_acc;
    logic              store_acc;
    logic              drain;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign empty     = (count_q == '0);
    assign req_ready = req_write ? ((count_q < FULL) && !flush) : 1'b1;
    assign load_acc  = req_valid && !req_write;
    assign store_acc = req_valid && req_write && req_ready;
    assign drain     = !empty && !load_acc;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    // An entry is live when its distance from head is below the occupancy count.
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_mask[i] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q);
        end
    end

    sb_forward_mux #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_forward_mux (
        .entry_addr_i  (addr_q),
        .entry_data_i  (data_q),
        .valid_i       (valid_mask),
        .tail_i        (tail_q),
        .lookup_addr_i (req_addr),
        .hit_o         (fwd_hit),
        .data_o        (fwd_data)
    );

    // Loads own the port; otherwise the head entry drains. Reset silences the port.
    always_comb begin
        mem_w     = 1'b0;
        mem_r     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (load_acc) begin
                mem_r    = 1'b1;
                mem_addr = req_addr;
            end else if (drain) begin
                mem_w     = 1'b1;
                mem_addr  = addr_q[head_q];
                mem_wdata = data_q[head_q];
            end
        end
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        rsp_valid_d = load_acc;
        rsp_data_d  = rsp_data_q;
        if (drain) begin
            head_d = head_q + 1'b1;
        end
        if (store_acc) begin
            tail_d = tail_q + 1'b1;
        end
        case ({store_acc, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (load_acc) begin
            rsp_data_d = fwd_hit ? fwd_data : mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Entry storage is deliberately left unreset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            addr_q[tail_q] <= req_addr;
            data_q[tail_q] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based store/memory model.
module tb_store_buffer;
    import mips_mem_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 24;
    localparam int DW    = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_write, flush;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready, rsp_valid, mem_w, mem_r, empty;
    logic [DW-1:0] rsp_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];
    logic          mem_init;

    sb_entry_t     q [$];
    logic [DW-1:0] exp_rsp_data;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_w     (mem_w),
        .mem_r     (mem_r),
        .mem_rdata (mem_rdata),
        .flush     (flush),
        .empty     (empty)
    );

    assign mem_rdata = mem_r ? mem[mem_addr[7:0]] : '0;

    always @(posedge clk) begin
        if (mem_w) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end else if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, advance model, check response.
    task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic f);
        logic      ready, load_acc, store_acc, drain, found;
        sb_entry_t h, e;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        flush     = f;
        #1;
        ready     = w ? ((q.size() < DEPTH) && !f) : 1'b1;
        load_acc  = v && !w;
        store_acc = v && w && ready;
        drain     = (q.size() > 0) && !load_acc;
        h         = '0;
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("req_ready", 32'(req_ready), 32'(ready));
        chk("mem_r", 32'(mem_r), 32'(load_acc));
        chk("mem_w", 32'(mem_w), 32'(drain));
        if (load_acc) begin
            chk("mem_addr_load", 32'(mem_addr), 32'(a));
            chk("mem_wdata_load", 32'(mem_wdata), 32'h0);
            exp_rsp_data = ref_mem[a[7:0]];
            found = 1'b0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!found && q[i].addr == a) begin
                    exp_rsp_data = q[i].data;
                    found = 1'b1;
                end
            end
        end else if (drain) begin
            h = q[0];
            chk("mem_addr_drain", 32'(mem_addr), 32'(h.addr));
            chk("mem_wdata_drain", 32'(mem_wdata), 32'(h.data));
        end else begin
            chk("mem_addr_idle", 32'(mem_addr), 32'h0);
            chk("mem_wdata_idle", 32'(mem_wdata), 32'h0);
        end
        if (drain) begin
            ref_mem[h.addr[7:0]] = h.data;
            void'(q.pop_front());
        end
        if (store_acc) begin
            e.addr = a;
            e.data = d;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(load_acc));
        chk("rsp_data", 32'(rsp_data), 32'(exp_rsp_data));
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        mem_init  = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 24'h000010;
        req_wdata = '0;
        flush     = 1'b0;
        exp_rsp_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = DW'($urandom);
        ref_mem[8'h10] = 24'h00ABCD;
        @(negedge clk);
        mem_init = 1'b0;

        // Reset state, with a load request present to confirm the port stays quiet.
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_mem_r", 32'(mem_r), 32'h0);
        chk("rst_mem_w", 32'(mem_w), 32'h0);
        req_valid = 1'b0;
        reset = 1'b0;

        // Load from memory.
        step(1'b1, 1'b0, 24'h000010, 24'h0, 1'b0);
        chk("load_mem_data", 32'(rsp_data), 32'h00ABCD);

        // Youngest forward.
        step(1'b1, 1'b1, 24'h000010, 24'h111111, 1'b0);
        step(1'b1, 1'b1, 24'h000010, 24'h222222, 1'b0);
        step(1'b1, 1'b0, 24'h000010, 24'h0, 1'b0);
        chk("fwd_youngest", 32'(rsp_data), 32'h222222);

        // Stores interleaved with port-holding loads, then release.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, AW'(24'h30 + i), DW'(i + 1), 1'b0);
            step(1'b1, 1'b0, 24'h000040, 24'h0, 1'b0);
        end
        step(1'b1, 1'b1, 24'h000034, 24'h000005, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);

        // Single store drains on the following idle cycle.
        step(1'b1, 1'b1, 24'h000020, 24'h000007, 1'b0);
        req_valid = 1'b0;
        #1;
        chk("drain_mem_w", 32'(mem_w), 32'h1);
        chk("drain_mem_addr", 32'(mem_addr), 32'h000020);
        chk("drain_mem_wdata", 32'(mem_wdata), 32'h000007);
        step(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
        chk("drain_empty", 32'(empty), 32'h1);

        // Flush refuses stores; reset in mid-drain silences the port at once.
        step(1'b1, 1'b1, 24'h000050, 24'h00000A, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b1;
        flush     = 1'b1;
        #1;
        chk("flush_refuse", 32'(req_ready), 32'h0);
        step(1'b1, 1'b1, 24'h000051, 24'h00000B, 1'b1);
        step(1'b1, 1'b1, 24'h000052, 24'h00000C, 1'b0);
        req_valid = 1'b0;
        flush     = 1'b1;
        #2;
        chk("pre_reset_mem_w", 32'(mem_w), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_reset_mem_w", 32'(mem_w), 32'h0);
        chk("mid_reset_empty", 32'(empty), 32'h1);
        chk("mid_reset_rsp_data", 32'(rsp_data), 32'h0);
        q.delete();
        exp_rsp_data = '0;
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;

        // Randomized traffic over a small address window to exercise forwarding.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 7) == 0);
        end
        for (int n = 0; n < 6; n++) step(1'b0, 1'b0, 24'h0, 24'h0, 1'b1);
        chk("final_empty", 32'(empty), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
